// File: rtl/down_timer.sv
// Loadable down-counter/timer: counts a loaded value to zero, flags terminal
// count, then either parks in DONE or reloads and keeps running.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not counting; y holds loaded or paused value
// RUN   | decrementing y each edge; tc while y==0
// DONE  | terminal count reached without auto-reload; y held at 0
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] y,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [WIDTH-1:0] reload_reg, reload_nxt;
  logic             y_zero;

  assign y_zero = (y == '0);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      y          <= '0;
      reload_reg <= '0;
    end else begin
      state      <= state_nxt;
      y          <= y_nxt;
      reload_reg <= reload_nxt;
    end
  end

  // Priority: load > stop > start. Zero is never decremented; the RUN/y==0
  // branch decides between reload and DONE instead.
  always_comb begin
    state_nxt  = state;
    y_nxt      = y;
    reload_nxt = reload_reg;
    if (load) begin
      y_nxt      = load_val;
      reload_nxt = load_val;
      state_nxt  = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!stop && start) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_nxt = S_IDLE;
          end else if (!y_zero) begin
            y_nxt = y - WIDTH'(1);
          end else if (auto_reload) begin
            y_nxt = reload_reg;
          end else begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (stop) begin
            state_nxt = S_IDLE;
          end else if (start) begin
            y_nxt     = reload_reg;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign tc   = busy && y_zero;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each step drives inputs, pushes the expected
// post-edge outputs to a scoreboard queue, then pops and compares after the edge.
module tb_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         res;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] y;
  logic         tc, busy, done;

  typedef struct packed {
    logic [W-1:0] y;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;

  // reference state: 0 idle, 1 run, 2 done
  int           m_st;
  logic [W-1:0] m_y;
  logic [W-1:0] m_rr;

  down_timer #(.WIDTH(W)) dut (
    .clk(clk), .res(res), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .auto_reload(auto_reload), .y(y), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    e.y    = m_y;
    e.busy = (m_st == 1);
    e.done = (m_st == 2);
    e.tc   = (m_st == 1) && (m_y == '0);
    return e;
  endfunction

  task automatic cmp(input string tag);
    exp_t e, a;
    e = sb.pop_front();
    a = {y, tc, busy, done};
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s got y=%0d tc=%0b busy=%0b done=%0b exp y=%0d tc=%0b busy=%0b done=%0b",
             tag, a.y, a.tc, a.busy, a.done, e.y, e.tc, e.busy, e.done);
    end
  endtask

  task automatic lit(input string tag, input logic [W-1:0] ey, input logic etc);
    checks++;
    assert ({y, tc} === {ey, etc}) else begin
      failures++;
      $error("FAIL %s got y=%0d tc=%0b exp y=%0d tc=%0b", tag, y, tc, ey, etc);
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic [W-1:0] lv,
                      input logic st, input logic sp, input logic ar);
    @(negedge clk);
    load = ld; load_val = lv; start = st; stop = sp; auto_reload = ar;
    if (ld) begin
      m_y = lv; m_rr = lv; m_st = 0;
    end else begin
      case (m_st)
        0: if (!sp && st) m_st = 1;
        1: if (sp) m_st = 0;
           else if (m_y != 0) m_y = m_y - 1'b1;
           else if (ar) m_y = m_rr;
           else m_st = 2;
        default: if (sp) m_st = 0;
                 else if (st) begin m_y = m_rr; m_st = 1; end
      endcase
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  task automatic idle(input string tag, input int n, input logic ar);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0, ar);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 res = 1'b0;
    m_st = 0; m_y = '0; m_rr = '0;
    sb.push_back(model_out());
    #1 cmp("async_reset");
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    res = 1'b0; load = 0; load_val = '0; start = 0; stop = 0; auto_reload = 0;
    m_st = 0; m_y = '0; m_rr = '0;
    #1;
    sb.push_back(model_out());
    cmp("reset_state");
    @(negedge clk);
    res = 1'b1;

    // 1: async reset mid-count
    step("t1_load", 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    step("t1_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("t1_run", 3, 1'b0);
    lit("t1_at5", 4'd5, 1'b0);
    do_reset();

    // 2: one-shot of 3
    step("t2_load", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step("t2_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    lit("t2_y3", 4'd3, 1'b0);
    idle("t2_run", 3, 1'b0);
    lit("t2_y0_tc", 4'd0, 1'b1);
    idle("t2_done_hold", 11, 1'b0);

    // 3: periodic reload of 2
    step("t3_load", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    step("t3_start", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle("t3_periodic", 12, 1'b1);
    step("t3_stop", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 4: pause and resume
    step("t4_load", 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step("t4_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("t4_run", 4, 1'b0);
    step("t4_stop", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("t4_paused", 4, 1'b0);
    lit("t4_held5", 4'd5, 1'b0);
    step("t4_resume", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("t4_finish", 6, 1'b0);

    // 5: load beats start in RUN; stop beats start in RUN
    step("t5_load", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step("t5_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("t5_run", 2, 1'b0);
    lit("t5_at4", 4'd4, 1'b0);
    step("t5_load_start", 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    step("t5_start2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    step("t5_stop_start", 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // 6: full-scale count, restart from DONE, zero load
    step("t6_load15", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step("t6_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle("t6_run", 15, 1'b0);
    lit("t6_tc", 4'd0, 1'b1);
    step("t6_to_done", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step("t6_restart", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    lit("t6_restart_y15", 4'd15, 1'b0);
    step("t6_load0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step("t6_start0", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    lit("t6_zero_tc", 4'd0, 1'b1);
    idle("t6_zero_done", 2, 1'b0);

    // zero reload with auto_reload keeps tc high
    step("t7_start", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle("t7_tc_held", 3, 1'b1);
    lit("t7_tc_high", 4'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
